decode_stage: RTL and testbench

- Instruction-decode stage of the Core101 pipeline, directly downstream of the instruction register and program counter in the fetch stage.
- Consumes the fetched 32-bit RV32I instruction word and its PC through a valid/ready handshake.
- Produces registered decoded fields, control bits and a sign-extended immediate for the execute stage.
- Holds one instruction in an output pipeline register; supports back-pressure and flush.

---
 rtl/decode_stage.sv | 317 +++++++++++++++++++++++++++++++
 tb/tb_decode_stage.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage with a single output pipeline register.
// Decodes the incoming instruction combinationally and registers the fields
// and control bits on acceptance. The stage supports valid/ready
// back-pressure and a flush input that discards both the held instruction
// and the incoming instruction.
// An illegal encoding is still delivered as a valid instruction so that
// downstream logic can raise the trap. Its register indices, immediate and
// ALU controls are zeroed. Only pc and funct3 are kept, for the trap handler.
module decode_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      decode_stage_clock_in,
  input  logic                      decode_stage_reset_in,
  input  logic [DATA_WIDTH-1:0]     decode_stage_ins_in,
  input  logic [DATA_WIDTH-1:0]     decode_stage_pc_in,
  input  logic                      decode_stage_valid_in,
  output logic                      decode_stage_ready_out,
  input  logic                      decode_stage_flush_in,
  input  logic                      decode_stage_ready_in,
  output logic                      decode_stage_valid_out,
  output logic [DATA_WIDTH-1:0]     decode_stage_pc_out,
  output logic [REG_ADDR_WIDTH-1:0] decode_stage_rs1_out,
  output logic [REG_ADDR_WIDTH-1:0] decode_stage_rs2_out,
  output logic [REG_ADDR_WIDTH-1:0] decode_stage_rd_out,
  output logic [DATA_WIDTH-1:0]     decode_stage_imm_out,
  output logic [2:0]                decode_stage_funct3_out,
  output logic [3:0]                decode_stage_alu_op_out,
  output logic                      decode_stage_alu_src_imm_out,
  output logic                      decode_stage_alu_src_pc_out,
  output logic                      decode_stage_reg_write_out,
  output logic                      decode_stage_mem_read_out,
  output logic                      decode_stage_mem_write_out,
  output logic                      decode_stage_branch_out,
  output logic                      decode_stage_jump_out,
  output logic                      decode_stage_illegal_out
);

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  // ALU operation codes
  localparam logic [3:0] ALU_ADD    = 4'b0000;
  localparam logic [3:0] ALU_SUB    = 4'b0001;
  localparam logic [3:0] ALU_SLL    = 4'b0010;
  localparam logic [3:0] ALU_SLT    = 4'b0011;
  localparam logic [3:0] ALU_SLTU   = 4'b0100;
  localparam logic [3:0] ALU_XOR    = 4'b0101;
  localparam logic [3:0] ALU_SRL    = 4'b0110;
  localparam logic [3:0] ALU_SRA    = 4'b0111;
  localparam logic [3:0] ALU_OR     = 4'b1000;
  localparam logic [3:0] ALU_AND    = 4'b1001;
  localparam logic [3:0] ALU_PASS_B = 4'b1010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [31:0] ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd_field;
  logic [4:0]  rs1_field;
  logic [4:0]  rs2_field;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign ins       = decode_stage_ins_in;
  assign opcode    = ins[6:0];
  assign rd_field  = ins[11:7];
  assign funct3    = ins[14:12];
  assign rs1_field = ins[19:15];
  assign rs2_field = ins[24:20];
  assign funct7    = ins[31:25];

  // Immediates, all sign-extended from bit 31. B and J immediates have an
  // implied zero in bit 0.
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'd0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};

  // Register-register and register-immediate ops share this funct3 mapping.
  // The alternate funct7 forms (SUB, SRA) are handled by the callers.
  function automatic logic [3:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

  // Decoded values for the incoming instruction
  logic [4:0]  rs1_next;
  logic [4:0]  rs2_next;
  logic [4:0]  rd_next;
  logic [31:0] imm_next;
  logic [3:0]  alu_op_next;
  logic        alu_src_imm_next;
  logic        alu_src_pc_next;
  logic        reg_write_next;
  logic        mem_read_next;
  logic        mem_write_next;
  logic        branch_next;
  logic        jump_next;
  logic        illegal_next;

  // Combinational decode of the instruction presented by fetch
  always_comb begin
    rs1_next         = 5'd0;
    rs2_next         = 5'd0;
    rd_next          = 5'd0;
    imm_next         = 32'd0;
    alu_op_next      = ALU_ADD;
    alu_src_imm_next = 1'b0;
    alu_src_pc_next  = 1'b0;
    reg_write_next   = 1'b0;
    mem_read_next    = 1'b0;
    mem_write_next   = 1'b0;
    branch_next      = 1'b0;
    jump_next        = 1'b0;
    illegal_next     = 1'b0;

    case (opcode)
      OPC_LUI: begin
        rd_next          = rd_field;
        imm_next         = imm_u;
        alu_op_next      = ALU_PASS_B;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_AUIPC: begin
        rd_next          = rd_field;
        imm_next         = imm_u;
        alu_src_imm_next = 1'b1;
        alu_src_pc_next  = 1'b1;
        reg_write_next   = 1'b1;
      end
      OPC_JAL: begin
        rd_next          = rd_field;
        imm_next         = imm_j;
        alu_src_imm_next = 1'b1;
        alu_src_pc_next  = 1'b1;
        reg_write_next   = 1'b1;
        jump_next        = 1'b1;
      end
      OPC_JALR: begin
        rd_next          = rd_field;
        rs1_next         = rs1_field;
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        alu_src_pc_next  = 1'b1;
        reg_write_next   = 1'b1;
        jump_next        = 1'b1;
        illegal_next     = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        rs1_next     = rs1_field;
        rs2_next     = rs2_field;
        imm_next     = imm_b;
        alu_op_next  = ALU_SUB;
        branch_next  = 1'b1;
        illegal_next = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_LOAD: begin
        rd_next          = rd_field;
        rs1_next         = rs1_field;
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
        mem_read_next    = 1'b1;
        // LB, LH, LW, LBU, LHU only
        illegal_next     = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        rs1_next         = rs1_field;
        rs2_next         = rs2_field;
        imm_next         = imm_s;
        alu_src_imm_next = 1'b1;
        mem_write_next   = 1'b1;
        illegal_next     = funct3[2] || (funct3[1:0] == 2'b11);
      end
      OPC_OP_IMM: begin
        rd_next          = rd_field;
        rs1_next         = rs1_field;
        imm_next         = imm_i;
        alu_src_imm_next = 1'b1;
        reg_write_next   = 1'b1;
        alu_op_next      = base_alu(funct3);
        // Shift-immediates carry a funct7 in the upper immediate bits
        if (funct3 == 3'b001) begin
          illegal_next = (funct7 != F7_BASE);
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_ALT) begin
            alu_op_next = ALU_SRA;
          end else if (funct7 != F7_BASE) begin
            illegal_next = 1'b1;
          end
        end
      end
      OPC_OP: begin
        rd_next        = rd_field;
        rs1_next       = rs1_field;
        rs2_next       = rs2_field;
        reg_write_next = 1'b1;
        alu_op_next    = base_alu(funct3);
        if (funct7 == F7_ALT) begin
          if (funct3 == 3'b000) begin
            alu_op_next = ALU_SUB;
          end else if (funct3 == 3'b101) begin
            alu_op_next = ALU_SRA;
          end else begin
            illegal_next = 1'b1;
          end
        end else if (funct7 != F7_BASE) begin
          illegal_next = 1'b1;
        end
      end
      OPC_FENCE: begin
        // Single-hart in-order core: FENCE behaves as a NOP
      end
      default: begin
        illegal_next = 1'b1;
      end
    endcase

    // Writes to x0 are discarded here so execute never has to check rd.
    if (rd_next == 5'd0) begin
      reg_write_next = 1'b0;
    end

    // A trapping instruction must have no architectural side effects.
    if (illegal_next) begin
      rs1_next         = 5'd0;
      rs2_next         = 5'd0;
      rd_next          = 5'd0;
      imm_next         = 32'd0;
      alu_op_next      = ALU_ADD;
      alu_src_imm_next = 1'b0;
      alu_src_pc_next  = 1'b0;
      reg_write_next   = 1'b0;
      mem_read_next    = 1'b0;
      mem_write_next   = 1'b0;
      branch_next      = 1'b0;
      jump_next        = 1'b0;
    end
  end

  logic accept;

  assign decode_stage_ready_out = !decode_stage_valid_out || decode_stage_ready_in;
  assign accept = decode_stage_valid_in && decode_stage_ready_out;

  // Output pipeline register. Flush wins over everything. The data fields
  // only change when a new instruction is accepted.
  always_ff @(posedge decode_stage_clock_in or posedge decode_stage_reset_in) begin
    if (decode_stage_reset_in) begin
      decode_stage_valid_out       <= 1'b0;
      decode_stage_pc_out          <= '0;
      decode_stage_rs1_out         <= '0;
      decode_stage_rs2_out         <= '0;
      decode_stage_rd_out          <= '0;
      decode_stage_imm_out         <= '0;
      decode_stage_funct3_out      <= 3'd0;
      decode_stage_alu_op_out      <= 4'd0;
      decode_stage_alu_src_imm_out <= 1'b0;
      decode_stage_alu_src_pc_out  <= 1'b0;
      decode_stage_reg_write_out   <= 1'b0;
      decode_stage_mem_read_out    <= 1'b0;
      decode_stage_mem_write_out   <= 1'b0;
      decode_stage_branch_out      <= 1'b0;
      decode_stage_jump_out        <= 1'b0;
      decode_stage_illegal_out     <= 1'b0;
    end else if (decode_stage_flush_in) begin
      decode_stage_valid_out <= 1'b0;
    end else if (accept) begin
      decode_stage_valid_out       <= 1'b1;
      decode_stage_pc_out          <= decode_stage_pc_in;
      decode_stage_rs1_out         <= rs1_next;
      decode_stage_rs2_out         <= rs2_next;
      decode_stage_rd_out          <= rd_next;
      decode_stage_imm_out         <= imm_next;
      decode_stage_funct3_out      <= funct3;
      decode_stage_alu_op_out      <= alu_op_next;
      decode_stage_alu_src_imm_out <= alu_src_imm_next;
      decode_stage_alu_src_pc_out  <= alu_src_pc_next;
      decode_stage_reg_write_out   <= reg_write_next;
      decode_stage_mem_read_out    <= mem_read_next;
      decode_stage_mem_write_out   <= mem_write_next;
      decode_stage_branch_out      <= branch_next;
      decode_stage_jump_out        <= jump_next;
      decode_stage_illegal_out     <= illegal_next;
    end else if (decode_stage_ready_in) begin
      decode_stage_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: a reference model of the held
// instruction is compared against the DUT every cycle. Directed checks with
// hand-computed values pin the model and the handshake corner cases.
module tb_decode_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [3:0]  alu_op;
    logic        src_imm;
    logic        src_pc;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        illegal;
  } dec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ins = 32'd0;
  logic [31:0] pc = 32'd0;
  logic        valid_in = 1'b0;
  logic        ready_in = 1'b0;
  logic        flush = 1'b0;

  logic        ready_out;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [4:0]  rs1_out;
  logic [4:0]  rs2_out;
  logic [4:0]  rd_out;
  logic [31:0] imm_out;
  logic [2:0]  funct3_out;
  logic [3:0]  alu_op_out;
  logic        src_imm_out;
  logic        src_pc_out;
  logic        reg_write_out;
  logic        mem_read_out;
  logic        mem_write_out;
  logic        branch_out;
  logic        jump_out;
  logic        illegal_out;

  int n_checks = 0;
  int n_pass   = 0;

  decode_stage dut (
    .decode_stage_clock_in        (clk),
    .decode_stage_reset_in        (rst),
    .decode_stage_ins_in          (ins),
    .decode_stage_pc_in           (pc),
    .decode_stage_valid_in        (valid_in),
    .decode_stage_ready_out       (ready_out),
    .decode_stage_flush_in        (flush),
    .decode_stage_ready_in        (ready_in),
    .decode_stage_valid_out       (valid_out),
    .decode_stage_pc_out          (pc_out),
    .decode_stage_rs1_out         (rs1_out),
    .decode_stage_rs2_out         (rs2_out),
    .decode_stage_rd_out          (rd_out),
    .decode_stage_imm_out         (imm_out),
    .decode_stage_funct3_out      (funct3_out),
    .decode_stage_alu_op_out      (alu_op_out),
    .decode_stage_alu_src_imm_out (src_imm_out),
    .decode_stage_alu_src_pc_out  (src_pc_out),
    .decode_stage_reg_write_out   (reg_write_out),
    .decode_stage_mem_read_out    (mem_read_out),
    .decode_stage_mem_write_out   (mem_write_out),
    .decode_stage_branch_out      (branch_out),
    .decode_stage_jump_out        (jump_out),
    .decode_stage_illegal_out     (illegal_out)
  );

  always #5 clk = ~clk;

  dec_t dut_d;
  assign dut_d = {pc_out, rs1_out, rs2_out, rd_out, imm_out, funct3_out, alu_op_out,
                  src_imm_out, src_pc_out, reg_write_out, mem_read_out, mem_write_out,
                  branch_out, jump_out, illegal_out};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_dec(input string name, input dec_t act, input dec_t exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Reference decoder: immediates are built by arithmetic on the bit
  // fields, and the ISA rules are applied class by class.
  function automatic dec_t model_decode(input logic [31:0] i, input logic [31:0] p);
    dec_t d;
    bit ok;
    int si;
    logic [3:0] base [8];
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [31:0] im_i, im_s, im_b, im_u, im_j;
    base = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc = i[6:0];
    f3  = i[14:12];
    f7  = i[31:25];
    si  = int'(i);
    im_i = 32'(si >>> 20);
    im_s = 32'((si >>> 20) & ~31) | {27'd0, i[11:7]};
    im_u = i & 32'hFFFF_F000;
    im_b = 32'((i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2);
    im_j = 32'((i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2);
    d = '0;
    d.pc = p;
    d.funct3 = f3;
    ok = 1'b1;
    case (opc)
      7'h37: begin d.rd = i[11:7]; d.imm = im_u; d.alu_op = 4'd10; d.src_imm = 1; d.reg_write = 1; end
      7'h17: begin d.rd = i[11:7]; d.imm = im_u; d.src_imm = 1; d.src_pc = 1; d.reg_write = 1; end
      7'h6F: begin d.rd = i[11:7]; d.imm = im_j; d.src_imm = 1; d.src_pc = 1; d.reg_write = 1; d.jump = 1; end
      7'h67: begin
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.imm = im_i; d.src_imm = 1; d.src_pc = 1;
        d.reg_write = 1; d.jump = 1; ok = (f3 == 3'd0);
      end
      7'h63: begin
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.imm = im_b; d.alu_op = 4'd1; d.branch = 1;
        ok = !(f3 == 3'd2 || f3 == 3'd3);
      end
      7'h03: begin
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.imm = im_i; d.src_imm = 1; d.reg_write = 1;
        d.mem_read = 1; ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      end
      7'h23: begin
        d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.imm = im_s; d.src_imm = 1; d.mem_write = 1;
        ok = (f3 <= 3'd2);
      end
      7'h13: begin
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.imm = im_i; d.src_imm = 1; d.reg_write = 1;
        d.alu_op = base[f3];
        if (f3 == 3'd1) ok = (f7 == 7'h00);
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) d.alu_op = 4'd7;
          else ok = (f7 == 7'h00);
        end
      end
      7'h33: begin
        d.rd = i[11:7]; d.rs1 = i[19:15]; d.rs2 = i[24:20]; d.reg_write = 1;
        if (f7 == 7'h00) d.alu_op = base[f3];
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu_op = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu_op = 4'd7;
        else ok = 1'b0;
      end
      7'h0F: ;
      default: ok = 1'b0;
    endcase
    if (d.rd == 5'd0) d.reg_write = 1'b0;
    if (!ok) begin
      d = '0;
      d.pc = p;
      d.funct3 = f3;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  // Model of the held instruction, updated on the same edges as the DUT
  logic exp_valid;
  dec_t exp_d;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_valid = 1'b0;
      exp_d = '0;
    end else if (flush) begin
      exp_valid = 1'b0;
    end else if (valid_in && (!exp_valid || ready_in)) begin
      exp_valid = 1'b1;
      exp_d = model_decode(ins, pc);
    end else if (ready_in) begin
      exp_valid = 1'b0;
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    check("ready_out", {31'd0, ready_out}, {31'd0, !exp_valid || ready_in});
    check("valid_out", {31'd0, valid_out}, {31'd0, exp_valid});
    check_dec("held_fields", dut_d, exp_d);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [31:0] i, input logic [31:0] p);
    ins = i;
    pc = p;
    valid_in = 1'b1;
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    check("reset_valid", {31'd0, valid_out}, 32'd0);
    check("reset_ready", {31'd0, ready_out}, 32'd1);
    check_dec("reset_fields", dut_d, '0);

    ready_in = 1'b1;
    // addi x1,x0,5
    send(32'h0050_0093, 32'h0);
    check("addi_valid", {31'd0, valid_out}, 32'd1);
    check("addi_rd", {27'd0, rd_out}, 32'd1);
    check("addi_rs1", {27'd0, rs1_out}, 32'd0);
    check("addi_imm", imm_out, 32'h5);
    check("addi_alu", {28'd0, alu_op_out}, 32'd0);
    check("addi_srcimm", {31'd0, src_imm_out}, 32'd1);
    check("addi_wr", {31'd0, reg_write_out}, 32'd1);

    // sub x3,x1,x2
    send(32'h4020_81B3, 32'h4);
    check("sub_rd", {27'd0, rd_out}, 32'd3);
    check("sub_rs1", {27'd0, rs1_out}, 32'd1);
    check("sub_rs2", {27'd0, rs2_out}, 32'd2);
    check("sub_alu", {28'd0, alu_op_out}, 32'd1);
    check("sub_srcimm", {31'd0, src_imm_out}, 32'd0);
    check("sub_wr", {31'd0, reg_write_out}, 32'd1);

    // beq x1,x2,-4
    send(32'hFE20_8EE3, 32'h100);
    check("beq_imm", imm_out, 32'hFFFF_FFFC);
    check("beq_branch", {31'd0, branch_out}, 32'd1);
    check("beq_funct3", {29'd0, funct3_out}, 32'd0);
    check("beq_wr", {31'd0, reg_write_out}, 32'd0);
    check("beq_pc", pc_out, 32'h100);

    // Back-pressure: lui x5,0x12345 waits while execute stalls
    ready_in = 1'b0;
    ins = 32'h1234_52B7;
    pc = 32'h104;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("hold_ready", {31'd0, ready_out}, 32'd0);
      check("hold_pc", pc_out, 32'h100);
      check("hold_imm", imm_out, 32'hFFFF_FFFC);
      check("hold_valid", {31'd0, valid_out}, 32'd1);
    end
    ready_in = 1'b1;
    tick();
    check("release_pc", pc_out, 32'h104);
    check("release_imm", imm_out, 32'h1234_5000);
    check("release_alu", {28'd0, alu_op_out}, 32'd10);
    check("release_rd", {27'd0, rd_out}, 32'd5);
    valid_in = 1'b0;
    tick();
    check("drain_valid", {31'd0, valid_out}, 32'd0);
    check("drain_pc_kept", pc_out, 32'h104);

    // Flush drops both the held lw and the incoming addi
    send(32'h0081_2303, 32'h200);
    check("lw_mem_read", {31'd0, mem_read_out}, 32'd1);
    check("lw_imm", imm_out, 32'h8);
    flush = 1'b1;
    send(32'h0050_0093, 32'h204);
    check("flush_valid", {31'd0, valid_out}, 32'd0);
    check("flush_pc_kept", pc_out, 32'h200);
    flush = 1'b0;
    valid_in = 1'b0;
    tick();
    check("after_flush_valid", {31'd0, valid_out}, 32'd0);

    // Illegal encodings are delivered with side effects suppressed
    send(32'hFFFF_FFFF, 32'h300);
    check("ffff_valid", {31'd0, valid_out}, 32'd1);
    check("ffff_illegal", {31'd0, illegal_out}, 32'd1);
    check("ffff_ctrl", {27'd0, reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out}, 32'd0);
    send(32'h0000_0073, 32'h304);
    check("ecall_valid", {31'd0, valid_out}, 32'd1);
    check("ecall_illegal", {31'd0, illegal_out}, 32'd1);
    check("ecall_ctrl", {27'd0, reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out}, 32'd0);

    // Remaining classes and boundary encodings
    send(32'h0100_00EF, 32'h400);  // jal x1,16
    check("jal_imm", imm_out, 32'h10);
    check("jal_ctrl", {29'd0, jump_out, src_pc_out, reg_write_out}, 32'd7);
    send(32'h0000_8067, 32'h404);  // jalr x0,0(x1): rd=0 so no write
    check("jalr_wr", {31'd0, reg_write_out}, 32'd0);
    check("jalr_rs1", {27'd0, rs1_out}, 32'd1);
    send(32'h0020_A623, 32'h408);  // sw x2,12(x1)
    check("sw_imm", imm_out, 32'hC);
    check("sw_ctrl", {30'd0, mem_write_out, reg_write_out}, 32'd2);
    send(32'h4030_D393, 32'h40C);  // srai x7,x1,3
    check("srai_alu", {28'd0, alu_op_out}, 32'd7);
    send(32'h4030_9393, 32'h410);  // slli with funct7=0100000
    check("slli_bad", {31'd0, illegal_out}, 32'd1);
    send(32'h0020_A063, 32'h414);  // branch funct3=010
    check("br_f3_bad", {31'd0, illegal_out}, 32'd1);
    send(32'h0000_1517, 32'h418);  // auipc x10,1
    check("auipc_imm", imm_out, 32'h1000);
    check("auipc_srcpc", {31'd0, src_pc_out}, 32'd1);
    send(32'h0FF0_000F, 32'h41C);  // fence
    check("fence_ctrl", {25'd0, reg_write_out, mem_read_out, mem_write_out, branch_out, jump_out, illegal_out, src_imm_out}, 32'd0);
    send(32'h0062_F233, 32'h420);  // and x4,x5,x6
    check("and_alu", {28'd0, alu_op_out}, 32'd9);
    send(32'h4062_E233, 32'h424);  // or with funct7=0100000
    check("or_alt_bad", {31'd0, illegal_out}, 32'd1);
    send(32'h0000_B003, 32'h428);  // load funct3=011
    check("ld_bad", {31'd0, illegal_out}, 32'd1);

    // Reset in the middle of a stall clears everything before the next edge
    send(32'h0050_0093, 32'h500);
    ready_in = 1'b0;
    ins = 32'h4020_81B3;
    pc = 32'h504;
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, valid_out}, 32'd0);
    check_dec("midrst_fields", dut_d, '0);
    check("midrst_ready", {31'd0, ready_out}, 32'd1);
    #3 rst = 1'b0;
    valid_in = 1'b0;
    tick();
    check("post_rst_valid", {31'd0, valid_out}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
